// File: rtl/lsu_ecc_scrub_pkg.sv
// rtl/lsu_ecc_scrub_pkg.sv - shared LSU scrub types and widths
package lsu_ecc_scrub_pkg;

    localparam int DCCM_BITS  = 16;
    localparam int DATA_WIDTH = 32;
    localparam int ECC_WIDTH  = 7;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        WR_LO,
        WR_HI
    } lsu_scrub_state_t;

    typedef struct packed {
        logic                  valid;
        logic [DCCM_BITS-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
    } scrub_entry_t;

endpackage

// File: rtl/lsu_ecc_scrub_if.sv
// rtl/lsu_ecc_scrub_if.sv - DC3/DC4 pipeline inputs and DCCM scrub write port
interface lsu_ecc_scrub_if;
    import lsu_ecc_scrub_pkg::*;

    logic                  single_ecc_error_hi_dc3;
    logic                  single_ecc_error_lo_dc3;
    logic                  lsu_double_ecc_error_dc3;
    logic [DCCM_BITS-1:0]  lsu_addr_dc3;
    logic [DCCM_BITS-1:0]  end_addr_dc3;
    logic [DATA_WIDTH-1:0] store_ecc_datafn_hi_dc3;
    logic [DATA_WIDTH-1:0] store_ecc_datafn_lo_dc3;
    logic                  lsu_commit_dc4;
    logic                  lsu_flush_dc4;
    logic                  ecc_wr_gnt;
    logic                  ecc_wr_req;
    logic [DCCM_BITS-1:0]  ecc_wr_addr;
    logic [DATA_WIDTH-1:0] ecc_wr_data;
    logic [ECC_WIDTH-1:0]  ecc_wr_ecc;
    logic                  ecc_wr_force;
    logic                  ecc_scrub_busy;
    logic                  ecc_scrub_drop;

    modport master (
        input  single_ecc_error_hi_dc3, single_ecc_error_lo_dc3, lsu_double_ecc_error_dc3,
        input  lsu_addr_dc3, end_addr_dc3, store_ecc_datafn_hi_dc3, store_ecc_datafn_lo_dc3,
        input  lsu_commit_dc4, lsu_flush_dc4, ecc_wr_gnt,
        output ecc_wr_req, ecc_wr_addr, ecc_wr_data, ecc_wr_ecc,
        output ecc_wr_force, ecc_scrub_busy, ecc_scrub_drop
    );

    modport slave (
        output single_ecc_error_hi_dc3, single_ecc_error_lo_dc3, lsu_double_ecc_error_dc3,
        output lsu_addr_dc3, end_addr_dc3, store_ecc_datafn_hi_dc3, store_ecc_datafn_lo_dc3,
        output lsu_commit_dc4, lsu_flush_dc4, ecc_wr_gnt,
        input  ecc_wr_req, ecc_wr_addr, ecc_wr_data, ecc_wr_ecc,
        input  ecc_wr_force, ecc_scrub_busy, ecc_scrub_drop
    );

endinterface

// File: rtl/lsu_ecc_scrub_encode.sv
// rtl/lsu_ecc_scrub_encode.sv - rvecc_encode: Hamming SECDED(39,32) check bit generator
module rvecc_encode (
    input  logic [31:0] din,
    output logic [6:0]  ecc_out
);

    // Data occupies codeword positions 3..38 that are not powers of two;
    // check bit b covers every position whose index has bit b set.
    always_comb begin
        int k;
        ecc_out = '0;
        k = 0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int b = 0; b < 6; b++) begin
                    if (p[b]) begin
                        ecc_out[b] = ecc_out[b] ^ din[k];
                    end
                end
                k = k + 1;
            end
        end
        ecc_out[6] = (^din) ^ (^ecc_out[5:0]);
    end

endmodule

// File: rtl/lsu_ecc_scrub.sv
// rtl/lsu_ecc_scrub.sv - captures SEC-corrected DCCM words in DC3 and writes them back once the op commits
module lsu_ecc_scrub
    import lsu_ecc_scrub_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           rst,
    lsu_ecc_scrub_if.master bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [DCCM_BITS-1:0] WORD_MASK = ~DCCM_BITS'(3);

    lsu_scrub_state_t      state;
    scrub_entry_t          lo_e;
    scrub_entry_t          hi_e;
    logic [CNT_W-1:0]      starve_cnt;

    logic                  sec;
    logic                  cap_win;
    logic                  capture;
    logic                  req;
    scrub_entry_t          cur_e;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ECC_WIDTH-1:0]  wr_ecc;

    assign sec = bus.single_ecc_error_hi_dc3 | bus.single_ecc_error_lo_dc3;

    // A new entry may be taken while idle or in the very cycle the last write retires.
    assign cap_win = (state == IDLE) |
                     (bus.ecc_wr_gnt & ((state == WR_HI) | ((state == WR_LO) & ~hi_e.valid)));
    assign capture = cap_win & sec & ~bus.lsu_double_ecc_error_dc3;

    assign req   = (state == WR_LO) | (state == WR_HI);
    assign cur_e = (state == WR_HI) ? hi_e : lo_e;

    assign wr_data            = req ? cur_e.data : '0;
    assign bus.ecc_wr_req     = req;
    assign bus.ecc_wr_addr    = req ? cur_e.addr : '0;
    assign bus.ecc_wr_data    = wr_data;
    assign bus.ecc_wr_ecc     = wr_ecc;
    assign bus.ecc_wr_force   = req & (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign bus.ecc_scrub_busy = (state != IDLE);
    assign bus.ecc_scrub_drop = ~rst & sec & ~bus.lsu_double_ecc_error_dc3 & ~cap_win;

    rvecc_encode u_ecc (
        .din     (wr_data),
        .ecc_out (wr_ecc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lo_e       <= '0;
            hi_e       <= '0;
            starve_cnt <= '0;
        end else begin
            if (req && !bus.ecc_wr_gnt) begin
                if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else begin
                starve_cnt <= '0;
            end

            case (state)
                IDLE: ;
                PEND: begin
                    if (bus.lsu_flush_dc4) begin
                        state      <= IDLE;
                        lo_e.valid <= 1'b0;
                        hi_e.valid <= 1'b0;
                    end else if (bus.lsu_commit_dc4) begin
                        state <= lo_e.valid ? WR_LO : WR_HI;
                    end
                end
                WR_LO: begin
                    if (bus.ecc_wr_gnt) begin
                        lo_e.valid <= 1'b0;
                        state      <= hi_e.valid ? WR_HI : IDLE;
                    end
                end
                WR_HI: begin
                    if (bus.ecc_wr_gnt) begin
                        state      <= IDLE;
                        lo_e.valid <= 1'b0;
                        hi_e.valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Capture overrides the retire transition above.
            if (capture) begin
                lo_e  <= '{valid: bus.single_ecc_error_lo_dc3,
                           addr:  bus.lsu_addr_dc3 & WORD_MASK,
                           data:  bus.store_ecc_datafn_lo_dc3};
                hi_e  <= '{valid: bus.single_ecc_error_hi_dc3,
                           addr:  bus.end_addr_dc3 & WORD_MASK,
                           data:  bus.store_ecc_datafn_hi_dc3};
                state <= PEND;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// tb/tb_lsu_ecc_scrub.sv - scoreboard bench for lsu_ecc_scrub
module tb_lsu_ecc_scrub;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   nwr = 0;
    exp_t sb[$];

    lsu_ecc_scrub_if bus ();

    lsu_ecc_scrub #(.STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_ecc(input logic [31:0] d);
        logic [38:1] cw;
        logic [6:0]  e;
        int          j;
        cw = '0;
        j  = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16 && pos != 32) begin
                cw[pos] = d[j];
                j++;
            end
        end
        e = '0;
        for (int i = 0; i < 6; i++)
            for (int pos = 1; pos <= 38; pos++)
                if (((pos >> i) & 1) == 1) e[i] = e[i] ^ cw[pos];
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    // Scoreboard: every granted write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.ecc_wr_req === 1'b1 && bus.ecc_wr_gnt === 1'b1) begin
            exp_t x;
            nwr++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write: got addr=%h data=%h, want no write", bus.ecc_wr_addr, bus.ecc_wr_data);
            end else begin
                x = sb.pop_front();
                if ({bus.ecc_wr_addr, bus.ecc_wr_data, bus.ecc_wr_ecc} !== {x.addr, x.data, exp_ecc(x.data)}) begin
                    errors++;
                    $display("FAIL sb_write: got %h/%h/%h want %h/%h/%h", bus.ecc_wr_addr, bus.ecc_wr_data,
                             bus.ecc_wr_ecc, x.addr, x.data, exp_ecc(x.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clr_dc3();
        bus.single_ecc_error_hi_dc3  = 1'b0;
        bus.single_ecc_error_lo_dc3  = 1'b0;
        bus.lsu_double_ecc_error_dc3 = 1'b0;
        bus.lsu_addr_dc3             = '0;
        bus.end_addr_dc3             = '0;
        bus.store_ecc_datafn_hi_dc3  = '0;
        bus.store_ecc_datafn_lo_dc3  = '0;
    endtask

    task automatic sec_in(input logic hi, input logic lo, input logic dbl, input logic [15:0] a,
                          input logic [15:0] ea, input logic [31:0] dlo, input logic [31:0] dhi);
        bus.single_ecc_error_hi_dc3  = hi;
        bus.single_ecc_error_lo_dc3  = lo;
        bus.lsu_double_ecc_error_dc3 = dbl;
        bus.lsu_addr_dc3             = a;
        bus.end_addr_dc3             = ea;
        bus.store_ecc_datafn_lo_dc3  = dlo;
        bus.store_ecc_datafn_hi_dc3  = dhi;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_dc3();
        bus.lsu_commit_dc4 = 1'b0;
        bus.lsu_flush_dc4  = 1'b0;
        bus.ecc_wr_gnt     = 1'b0;
        step();
        step();
        mid();
        checks++;
        if ({bus.ecc_wr_req, bus.ecc_wr_force, bus.ecc_scrub_busy, bus.ecc_scrub_drop,
             bus.ecc_wr_addr, bus.ecc_wr_data, bus.ecc_wr_ecc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b busy=%b addr=%h data=%h, want all 0",
                     bus.ecc_wr_req, bus.ecc_scrub_busy, bus.ecc_wr_addr, bus.ecc_wr_data);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_lo();
        step();
        sec_in(1'b0, 1'b1, 1'b0, 16'h0104, 16'h0107, 32'hDEADBEEF, 32'h0);
        sb.push_back('{16'h0104, 32'hDEADBEEF});
        mid();
        checks++;
        if (bus.ecc_scrub_busy !== 1'b0 || bus.ecc_scrub_drop !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: busy=%b drop=%b want 0/0", bus.ecc_scrub_busy, bus.ecc_scrub_drop);
        end
        step();
        clr_dc3();
        bus.lsu_commit_dc4 = 1'b1;
        mid();
        checks++;
        if (bus.ecc_scrub_busy !== 1'b1 || bus.ecc_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL single_pend: busy=%b req=%b want 1/0", bus.ecc_scrub_busy, bus.ecc_wr_req);
        end
        step();
        bus.lsu_commit_dc4 = 1'b0;
        bus.ecc_wr_gnt     = 1'b1;
        mid();
        checks++;
        if ({bus.ecc_wr_req, bus.ecc_wr_addr, bus.ecc_wr_data, bus.ecc_wr_ecc} !==
            {1'b1, 16'h0104, 32'hDEADBEEF, exp_ecc(32'hDEADBEEF)}) begin
            errors++;
            $display("FAIL single_req: req=%b addr=%h data=%h ecc=%h want 1/0104/deadbeef/%h", bus.ecc_wr_req,
                     bus.ecc_wr_addr, bus.ecc_wr_data, bus.ecc_wr_ecc, exp_ecc(32'hDEADBEEF));
        end
        step();
        bus.ecc_wr_gnt = 1'b0;
        mid();
        checks++;
        if (bus.ecc_scrub_busy !== 1'b0 || bus.ecc_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL single_done: busy=%b req=%b want 0/0", bus.ecc_scrub_busy, bus.ecc_wr_req);
        end
    endtask

    task automatic test_dual_starve();
        step();
        sec_in(1'b1, 1'b1, 1'b0, 16'h0106, 16'h0109, 32'h11112222, 32'h33334444);
        sb.push_back('{16'h0104, 32'h11112222});
        sb.push_back('{16'h0108, 32'h33334444});
        step();
        clr_dc3();
        bus.lsu_commit_dc4 = 1'b1;
        step();
        bus.lsu_commit_dc4 = 1'b0;
        bus.ecc_wr_gnt     = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            mid();
            checks++;
            if (bus.ecc_wr_req !== 1'b1 || bus.ecc_wr_addr !== 16'h0104 ||
                bus.ecc_wr_force !== (i >= 9)) begin
                errors++;
                $display("FAIL dual_starve_%0d: req=%b addr=%h force=%b want 1/0104/%b", i,
                         bus.ecc_wr_req, bus.ecc_wr_addr, bus.ecc_wr_force, (i >= 9));
            end
            step();
        end
        bus.ecc_wr_gnt = 1'b1;
        mid();
        checks++;
        if (bus.ecc_wr_force !== 1'b1 || bus.ecc_wr_addr !== 16'h0104) begin
            errors++;
            $display("FAIL dual_lo_gnt: force=%b addr=%h want 1/0104", bus.ecc_wr_force, bus.ecc_wr_addr);
        end
        step();
        mid();
        checks++;
        if ({bus.ecc_wr_req, bus.ecc_wr_force, bus.ecc_wr_addr, bus.ecc_wr_data} !==
            {1'b1, 1'b0, 16'h0108, 32'h33334444}) begin
            errors++;
            $display("FAIL dual_hi: req=%b force=%b addr=%h data=%h want 1/0/0108/33334444",
                     bus.ecc_wr_req, bus.ecc_wr_force, bus.ecc_wr_addr, bus.ecc_wr_data);
        end
        step();
        bus.ecc_wr_gnt = 1'b0;
        mid();
        checks++;
        if (bus.ecc_scrub_busy !== 1'b0) begin
            errors++;
            $display("FAIL dual_done: busy=%b want 0", bus.ecc_scrub_busy);
        end
    endtask

    task automatic test_double();
        step();
        sec_in(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0043, 32'hFFFF0000, 32'h0);
        mid();
        checks++;
        if (bus.ecc_scrub_drop !== 1'b0) begin
            errors++;
            $display("FAIL double_drop: drop=%b want 0", bus.ecc_scrub_drop);
        end
        step();
        clr_dc3();
        bus.lsu_commit_dc4 = 1'b1;
        mid();
        checks++;
        if (bus.ecc_scrub_busy !== 1'b0) begin
            errors++;
            $display("FAIL double_busy: busy=%b want 0", bus.ecc_scrub_busy);
        end
        step();
        bus.lsu_commit_dc4 = 1'b0;
        mid();
        checks++;
        if (bus.ecc_wr_req !== 1'b0 || bus.ecc_scrub_busy !== 1'b0) begin
            errors++;
            $display("FAIL double_req: req=%b busy=%b want 0/0", bus.ecc_wr_req, bus.ecc_scrub_busy);
        end
    endtask

    task automatic test_flush();
        logic seen;
        step();
        sec_in(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0087, 32'h0000AAAA, 32'h5555FFFF);
        step();
        clr_dc3();
        bus.lsu_commit_dc4 = 1'b1;
        bus.lsu_flush_dc4  = 1'b1;
        mid();
        checks++;
        if (bus.ecc_scrub_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_pend: busy=%b want 1", bus.ecc_scrub_busy);
        end
        step();
        bus.lsu_commit_dc4 = 1'b0;
        bus.lsu_flush_dc4  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            if (bus.ecc_wr_req !== 1'b0 || bus.ecc_scrub_busy !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: req or busy seen=%b want 0", seen);
        end
    endtask

    task automatic test_drop_recapture();
        step();
        sec_in(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0013, 32'hCAFEF00D, 32'h0);
        sb.push_back('{16'h0010, 32'hCAFEF00D});
        step();
        clr_dc3();
        bus.lsu_commit_dc4 = 1'b1;
        step();
        bus.lsu_commit_dc4 = 1'b0;
        bus.ecc_wr_gnt     = 1'b0;
        step();
        sec_in(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0023, 32'h0BADC0DE, 32'h0);
        mid();
        checks++;
        if (bus.ecc_scrub_drop !== 1'b1 || bus.ecc_wr_addr !== 16'h0010) begin
            errors++;
            $display("FAIL drop_pulse: drop=%b addr=%h want 1/0010", bus.ecc_scrub_drop, bus.ecc_wr_addr);
        end
        step();
        clr_dc3();
        mid();
        checks++;
        if (bus.ecc_scrub_drop !== 1'b0 || bus.ecc_wr_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL drop_after: drop=%b data=%h want 0/cafef00d", bus.ecc_scrub_drop, bus.ecc_wr_data);
        end
        step();
        bus.ecc_wr_gnt = 1'b1;
        sec_in(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0203, 32'h5A5A0F0F, 32'h0);
        sb.push_back('{16'h0200, 32'h5A5A0F0F});
        mid();
        checks++;
        if (bus.ecc_scrub_drop !== 1'b0) begin
            errors++;
            $display("FAIL recapture_drop: drop=%b want 0", bus.ecc_scrub_drop);
        end
        step();
        bus.ecc_wr_gnt     = 1'b0;
        clr_dc3();
        bus.lsu_commit_dc4 = 1'b1;
        mid();
        checks++;
        if (bus.ecc_scrub_busy !== 1'b1 || bus.ecc_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL recapture_pend: busy=%b req=%b want 1/0", bus.ecc_scrub_busy, bus.ecc_wr_req);
        end
        step();
        bus.lsu_commit_dc4 = 1'b0;
        bus.ecc_wr_gnt     = 1'b1;
        mid();
        checks++;
        if (bus.ecc_wr_req !== 1'b1 || bus.ecc_wr_addr !== 16'h0200) begin
            errors++;
            $display("FAIL recapture_req: req=%b addr=%h want 1/0200", bus.ecc_wr_req, bus.ecc_wr_addr);
        end
        step();
        bus.ecc_wr_gnt = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        step();
        sec_in(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0307, 32'h01234567, 32'h89ABCDEF);
        sb.push_back('{16'h0300, 32'h01234567});
        step();
        clr_dc3();
        bus.lsu_commit_dc4 = 1'b1;
        step();
        bus.lsu_commit_dc4 = 1'b0;
        bus.ecc_wr_gnt     = 1'b1;
        step();
        bus.ecc_wr_gnt = 1'b0;
        rst            = 1'b1;
        mid();
        checks++;
        if (bus.ecc_wr_req !== 1'b1 || bus.ecc_wr_addr !== 16'h0304) begin
            errors++;
            $display("FAIL rstmid_hi: req=%b addr=%h want 1/0304", bus.ecc_wr_req, bus.ecc_wr_addr);
        end
        step();
        rst = 1'b0;
        mid();
        checks++;
        if ({bus.ecc_wr_req, bus.ecc_wr_force, bus.ecc_scrub_busy, bus.ecc_scrub_drop,
             bus.ecc_wr_addr, bus.ecc_wr_data, bus.ecc_wr_ecc} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: req=%b busy=%b addr=%h data=%h want all 0",
                     bus.ecc_wr_req, bus.ecc_scrub_busy, bus.ecc_wr_addr, bus.ecc_wr_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            mid();
            if (bus.ecc_wr_req !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_noreq: req seen=%b want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_lo();
        test_dual_starve();
        test_double();
        test_flush();
        test_drop_recapture();
        test_reset_mid();
        step();
        checks++;
        if (sb.size() != 0 || nwr != 6) begin
            errors++;
            $display("FAIL sb_final: pending=%0d writes=%0d want 0/6", sb.size(), nwr);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
